// File: rtl/sliced_logic_unit_pkg.sv
// Shared constants for the sliced logic unit: op encoding, FSM state encoding
// and field widths. Imported by the top module and the slice datapath.
package sliced_logic_unit_pkg;

    // Width of the function-select field
    localparam int OP_W = 3;

    // Bitwise function encodings
    localparam logic [OP_W-1:0] OP_AND   = 3'b000;
    localparam logic [OP_W-1:0] OP_OR    = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR   = 3'b010;
    localparam logic [OP_W-1:0] OP_NAND  = 3'b011;
    localparam logic [OP_W-1:0] OP_NOR   = 3'b100;
    localparam logic [OP_W-1:0] OP_XNOR  = 3'b101;
    localparam logic [OP_W-1:0] OP_ANDN  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASSA = 3'b111;

    // Control FSM state encoding
    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'b00;
    localparam logic [ST_W-1:0] ST_BUSY = 2'b01;
    localparam logic [ST_W-1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/sliced_logic_unit_logic_slice.sv
// One SLICE-bit wide gate slice implementing all eight bitwise functions.
// Purely combinational; the top module time-multiplexes it over the operand.
module logic_slice
    import sliced_logic_unit_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [OP_W-1:0]  op,
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    output logic [SLICE-1:0] y_s
);

    // Select the requested bitwise function for this slice
    always_comb begin
        y_s = '0;
        case (op)
            OP_AND:   y_s = a_s & b_s;
            OP_OR:    y_s = a_s | b_s;
            OP_XOR:   y_s = a_s ^ b_s;
            OP_NAND:  y_s = ~(a_s & b_s);
            OP_NOR:   y_s = ~(a_s | b_s);
            OP_XNOR:  y_s = ~(a_s ^ b_s);
            OP_ANDN:  y_s = a_s & ~b_s;
            OP_PASSA: y_s = a_s;
            default:  y_s = '0;
        endcase
    end

endmodule

// File: rtl/sliced_logic_unit.sv
// Multi-operation bitwise logic unit. Operands are captured on acceptance and
// processed SLICE bits per cycle through a single gate slice; the assembled
// result and its zero flag are held until the consumer takes them.
module sliced_logic_unit
    import sliced_logic_unit_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    // A single-slice configuration still gets a 1-bit index that never moves
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    logic [ST_W-1:0]  state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;

    logic [SLICE-1:0] a_s, b_s, y_s;
    logic [WIDTH-1:0] res_written;

    // Route the captured operand slice addressed by the index to the gate slice
    always_comb begin
        a_s = '0;
        b_s = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_s = a_q[i*SLICE +: SLICE];
                b_s = b_q[i*SLICE +: SLICE];
            end
        end
    end

    logic_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .op  (op_q),
        .a_s (a_s),
        .b_s (b_s),
        .y_s (y_s)
    );

    // Merge the fresh slice result into the partial result at the current index
    always_comb begin
        res_written = res_q;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                res_written[i*SLICE +: SLICE] = y_s;
            end
        end
    end

    // Control FSM: capture in IDLE, one slice per cycle in BUSY, hold in DONE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    res_d   = '0;
                    zero_d  = 1'b0;
                    idx_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                res_d = res_written;
                if (idx_q == IDX_LAST) begin
                    // Zero flag comes from the complete result, including this slice
                    zero_d  = (res_written == '0);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                // No re-accept on the consume edge; IDLE gets its own cycle
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous abort on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign res       = res_q;
    assign zero      = zero_q;

endmodule
